// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT input BRAM loader.
// Region depths, loader state encoding and counter sizing.
package gat_pkg;

  localparam int GAT_H_DATA_DEPTH = 242101;
  localparam int GAT_NODE_INFO_DEPTH = 13264;
  localparam int GAT_WEIGHT_DEPTH = 16 * 1433;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_H,
    LOAD_NI,
    LOAD_W,
    DONE
  } ld_state_e;

  function automatic int cnt_w_of(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m + 1;
  endfunction

  localparam int GAT_CNT_W = cnt_w_of(
    $clog2(GAT_H_DATA_DEPTH),
    $clog2(GAT_NODE_INFO_DEPTH),
    $clog2(GAT_WEIGHT_DEPTH)
  );

endpackage

// File: rtl/gat_bram_wr_port.sv
// Registered BRAM write port stage.
// Strobes for one cycle per write; data/address hold between writes.
module gat_bram_wr_port #(
  parameter int DW = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DW-1:0]     data,
  input  logic [ADDR_W-1:0] idx,
  output logic [DW-1:0]     din,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W+1:0] addra
);

  // Capture one beat; byte address is word index times four.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din   <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
    end else begin
      ena <= wr_en;
      wea <= wr_en;
      if (wr_en) begin
        din   <= data;
        addra <= {idx, 2'b00};
      end
    end
  end

endmodule

// File: rtl/gat_bram_loader.sv
// Splits one word stream into the three GAT input BRAMs.
// Region lengths come from the counter; tlast is only cross-checked.
module gat_bram_loader
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int H_DATA_DEPTH = GAT_H_DATA_DEPTH,
  parameter int NODE_INFO_DEPTH = GAT_NODE_INFO_DEPTH,
  parameter int WEIGHT_DEPTH = GAT_WEIGHT_DEPTH,
  parameter int H_DATA_ADDR_W = $clog2(H_DATA_DEPTH),
  parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  parameter int WEIGHT_ADDR_W = $clog2(WEIGHT_DEPTH),
  parameter int CNT_W = cnt_w_of(
    H_DATA_ADDR_W, NODE_INFO_ADDR_W, WEIGHT_ADDR_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TOP_WIDTH-1:0]      s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  output logic [TOP_WIDTH-1:0]      h_data_bram_din,
  output logic                      h_data_bram_ena,
  output logic                      h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]  h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]      h_node_info_bram_din,
  output logic                      h_node_info_bram_ena,
  output logic                      h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]      wgt_bram_din,
  output logic                      wgt_bram_ena,
  output logic                      wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]  wgt_bram_addra,
  output logic                      h_data_bram_load_done,
  output logic                      h_node_info_bram_load_done,
  output logic                      wgt_bram_load_done,
  output logic                      busy,
  output logic                      tlast_err
);

  ld_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_idx;
  logic             beat;
  logic             is_last;
  logic             fin_h;
  logic             fin_ni;
  logic             fin_w;

  assign beat    = s_tvalid & s_tready;
  assign is_last = (cnt == last_idx);

  // Final word index of the region being loaded.
  always_comb begin
    last_idx = '0;
    unique case (state)
      LOAD_H:  last_idx = CNT_W'(H_DATA_DEPTH - 1);
      LOAD_NI: last_idx = CNT_W'(NODE_INFO_DEPTH - 1);
      LOAD_W:  last_idx = CNT_W'(WEIGHT_DEPTH - 1);
      default: last_idx = '0;
    endcase
  end

  // Loader FSM, beat counter, done pipeline and tlast check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= IDLE;
      cnt                        <= '0;
      s_tready                   <= 1'b0;
      busy                       <= 1'b0;
      tlast_err                  <= 1'b0;
      fin_h                      <= 1'b0;
      fin_ni                     <= 1'b0;
      fin_w                      <= 1'b0;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
    end else begin
      fin_h  <= beat & is_last & (state == LOAD_H);
      fin_ni <= beat & is_last & (state == LOAD_NI);
      fin_w  <= beat & is_last & (state == LOAD_W);
      h_data_bram_load_done <= h_data_bram_load_done | fin_h;
      h_node_info_bram_load_done <=
        h_node_info_bram_load_done | fin_ni;
      wgt_bram_load_done <= wgt_bram_load_done | fin_w;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state                      <= LOAD_H;
            cnt                        <= '0;
            s_tready                   <= 1'b1;
            busy                       <= 1'b1;
            tlast_err                  <= 1'b0;
            fin_h                      <= 1'b0;
            fin_ni                     <= 1'b0;
            fin_w                      <= 1'b0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
          end
        end
        LOAD_H, LOAD_NI, LOAD_W: begin
          if (beat) begin
            if (s_tlast != is_last) tlast_err <= 1'b1;
            if (is_last) begin
              cnt <= '0;
              if (state == LOAD_H) begin
                state <= LOAD_NI;
              end else if (state == LOAD_NI) begin
                state <= LOAD_W;
              end else begin
                state    <= DONE;
                s_tready <= 1'b0;
                busy     <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  gat_bram_wr_port #(
    .DW     (TOP_WIDTH),
    .ADDR_W (H_DATA_ADDR_W)
  ) u_h_port (
    .clk   (clk),
    .rst   (rst),
    .wr_en (beat & (state == LOAD_H)),
    .data  (s_tdata),
    .idx   (cnt[H_DATA_ADDR_W-1:0]),
    .din   (h_data_bram_din),
    .ena   (h_data_bram_ena),
    .wea   (h_data_bram_wea),
    .addra (h_data_bram_addra)
  );

  gat_bram_wr_port #(
    .DW     (TOP_WIDTH),
    .ADDR_W (NODE_INFO_ADDR_W)
  ) u_ni_port (
    .clk   (clk),
    .rst   (rst),
    .wr_en (beat & (state == LOAD_NI)),
    .data  (s_tdata),
    .idx   (cnt[NODE_INFO_ADDR_W-1:0]),
    .din   (h_node_info_bram_din),
    .ena   (h_node_info_bram_ena),
    .wea   (h_node_info_bram_wea),
    .addra (h_node_info_bram_addra)
  );

  gat_bram_wr_port #(
    .DW     (TOP_WIDTH),
    .ADDR_W (WEIGHT_ADDR_W)
  ) u_w_port (
    .clk   (clk),
    .rst   (rst),
    .wr_en (beat & (state == LOAD_W)),
    .data  (s_tdata),
    .idx   (cnt[WEIGHT_ADDR_W-1:0]),
    .din   (wgt_bram_din),
    .ena   (wgt_bram_ena),
    .wea   (wgt_bram_wea),
    .addra (wgt_bram_addra)
  );

endmodule

// File: tb/tb_gat_bram_loader.sv
// Bench for gat_bram_loader with small region depths 4/3/2.
// Directed tables, corner sequences and random traffic vs a word-count model.
module tb_gat_bram_loader;

  localparam int DH = 4;
  localparam int DN = 3;
  localparam int DWT = 2;
  localparam int TOT = DH + DN + DWT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] h_din, ni_din, w_din;
  logic        h_ena, ni_ena, w_ena;
  logic        h_wea, ni_wea, w_wea;
  logic [3:0]  h_addr, ni_addr;
  logic [2:0]  w_addr;
  logic        h_done, ni_done, w_done;
  logic        busy, tlast_err;

  gat_bram_loader #(
    .TOP_WIDTH       (32),
    .H_DATA_DEPTH    (DH),
    .NODE_INFO_DEPTH (DN),
    .WEIGHT_DEPTH    (DWT)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .s_tdata                    (s_tdata),
    .s_tvalid                   (s_tvalid),
    .s_tready                   (s_tready),
    .s_tlast                    (s_tlast),
    .h_data_bram_din            (h_din),
    .h_data_bram_ena            (h_ena),
    .h_data_bram_wea            (h_wea),
    .h_data_bram_addra          (h_addr),
    .h_node_info_bram_din       (ni_din),
    .h_node_info_bram_ena       (ni_ena),
    .h_node_info_bram_wea       (ni_wea),
    .h_node_info_bram_addra     (ni_addr),
    .wgt_bram_din               (w_din),
    .wgt_bram_ena               (w_ena),
    .wgt_bram_wea               (w_wea),
    .wgt_bram_addra             (w_addr),
    .h_data_bram_load_done      (h_done),
    .h_node_info_bram_load_done (ni_done),
    .wgt_bram_load_done         (w_done),
    .busy                       (busy),
    .tlast_err                  (tlast_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: words accepted so far in this load, one-edge-delayed copy
  logic        m_armed;
  int          m_k;
  int          m_kd;
  logic        m_err;
  logic [2:0]  m_ena;
  logic [31:0] m_din [3];
  logic [31:0] m_addr [3];

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          port;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [TOT];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic m_busy();
    return m_armed && (m_k < TOT);
  endfunction

  function automatic logic is_final(input int k);
    return (k == DH - 1) || (k == DH + DN - 1) || (k == TOT - 1);
  endfunction

  task automatic model_reset();
    m_armed = 1'b0;
    m_k = 0;
    m_kd = 0;
    m_err = 1'b0;
    m_ena = '0;
    for (int r = 0; r < 3; r++) begin
      m_din[r] = '0;
      m_addr[r] = '0;
    end
  endtask

  task automatic model_edge();
    int r;
    int off;
    int kd_n;
    m_ena = '0;
    if (start && !m_busy()) begin
      m_armed = 1'b1;
      m_k = 0;
      m_kd = 0;
      m_err = 1'b0;
    end else begin
      kd_n = m_k;
      if (s_tvalid && m_busy()) begin
        if (m_k < DH) begin
          r = 0; off = m_k;
        end else if (m_k < DH + DN) begin
          r = 1; off = m_k - DH;
        end else begin
          r = 2; off = m_k - DH - DN;
        end
        m_ena[r] = 1'b1;
        m_din[r] = s_tdata;
        m_addr[r] = 32'(off * 4);
        if (s_tlast != is_final(m_k)) m_err = 1'b1;
        m_k++;
      end
      m_kd = kd_n;
    end
  endtask

  task automatic check_all();
    logic [31:0] ad [3];
    logic [31:0] aa [3];
    logic [2:0]  ae, aw;
    string       nm [3];
    nm[0] = "h"; nm[1] = "ni"; nm[2] = "w";
    ad[0] = h_din; ad[1] = ni_din; ad[2] = w_din;
    aa[0] = 32'(h_addr); aa[1] = 32'(ni_addr); aa[2] = 32'(w_addr);
    ae = {w_ena, ni_ena, h_ena};
    aw = {w_wea, ni_wea, h_wea};
    chk("s_tready", 32'(s_tready), 32'(m_busy()));
    chk("busy", 32'(busy), 32'(m_busy()));
    for (int r = 0; r < 3; r++) begin
      chk({nm[r], "_ena"}, 32'(ae[r]), 32'(m_ena[r]));
      chk({nm[r], "_wea"}, 32'(aw[r]), 32'(m_ena[r]));
      chk({nm[r], "_din"}, ad[r], m_din[r]);
      chk({nm[r], "_addra"}, aa[r], m_addr[r]);
    end
    chk("h_done", 32'(h_done), 32'(m_kd >= DH));
    chk("ni_done", 32'(ni_done), 32'(m_kd >= DH + DN));
    chk("w_done", 32'(w_done), 32'(m_kd >= TOT));
    chk("tlast_err", 32'(tlast_err), 32'(m_err));
  endtask

  task automatic step(input logic v, input logic [31:0] d,
                      input logic l, input logic st);
    @(negedge clk);
    s_tvalid = v;
    s_tdata = d;
    s_tlast = l;
    start = st;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_h_ena", 32'(h_ena), 32'd0);
    chk("rst_w_done", 32'(w_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_tbl(input int i);
    logic [2:0]  ae;
    logic [31:0] ad [3];
    logic [31:0] aa [3];
    ae = {w_ena, ni_ena, h_ena};
    ad[0] = h_din; ad[1] = ni_din; ad[2] = w_din;
    aa[0] = 32'(h_addr); aa[1] = 32'(ni_addr); aa[2] = 32'(w_addr);
    chk("tbl_ena", 32'(ae), 32'(1 << tbl[i].port));
    chk("tbl_din", ad[tbl[i].port], tbl[i].d);
    chk("tbl_addra", aa[tbl[i].port], tbl[i].addr);
  endtask

  task automatic stream(input int n, input int bad_idx);
    for (int i = 0; i < n; i++)
      step(1'b1, 32'h100 + 32'(i), is_final(i) ^ (i == bad_idx), 1'b0);
  endtask

  initial begin
    tbl[0] = '{32'h10, 1'b0, 0, 32'd0};
    tbl[1] = '{32'h11, 1'b0, 0, 32'd4};
    tbl[2] = '{32'h12, 1'b0, 0, 32'd8};
    tbl[3] = '{32'h13, 1'b1, 0, 32'd12};
    tbl[4] = '{32'h14, 1'b0, 1, 32'd0};
    tbl[5] = '{32'h15, 1'b0, 1, 32'd4};
    tbl[6] = '{32'h16, 1'b1, 1, 32'd8};
    tbl[7] = '{32'h17, 1'b0, 2, 32'd0};
    tbl[8] = '{32'h18, 1'b1, 2, 32'd4};

    model_reset();
    do_reset();

    // continuous valid
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < TOT; i++) begin
      step(1'b1, tbl[i].d, tbl[i].l, 1'b0);
      chk_tbl(i);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

    // start in DONE, then valid toggling every other cycle
    step(1'b0, '0, 1'b0, 1'b1);
    chk("restart_h_done", 32'(h_done), 32'd0);
    for (int i = 0; i < TOT; i++) begin
      step(1'b1, tbl[i].d, tbl[i].l, 1'b0);
      chk_tbl(i);
      step(1'b0, 32'hdead, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

    // tlast on H beat 1
    step(1'b0, '0, 1'b0, 1'b1);
    stream(TOT, 1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("tlast_err_sticky", 32'(tlast_err), 32'd1);

    // reset after two H beats
    step(1'b0, '0, 1'b0, 1'b1);
    stream(2, -1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    stream(TOT, -1);
    step(1'b0, '0, 1'b0, 1'b0);

    // start while in LOAD_NI is ignored
    step(1'b0, '0, 1'b0, 1'b1);
    stream(5, -1);
    step(1'b1, 32'h55, 1'b0, 1'b1);
    for (int i = 6; i < TOT; i++)
      step(1'b1, 32'h200 + 32'(i), is_final(i), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    stream(TOT, -1);

    // beats offered in IDLE
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h99, 1'b1, 1'b0);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      logic st, v, l;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 19) == 0);
        v = ($urandom_range(0, 2) != 0);
        l = is_final(m_k) ^ ($urandom_range(0, 24) == 0);
        step(v, $urandom, l, st);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
